// File: rtl/multi_channel_clock_gater.sv
// NUM_CH-channel idle-driven clock gater: per-channel RUN/OFF/WAKE FSM with a glitch-free latch+AND cell.
// Define CG_GATE_STATS_EN to add GATE_CNT, a saturating 16-bit count of gating events per channel.
module mcg_channel #(
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              CLKIN,
    input  logic              RSTN,
    input  logic              te_i,
    input  logic              busy_i,
    input  logic              force_i,
    input  logic [IDLE_W-1:0] thresh_i,
    output logic              clk_o,
    output logic              ready_o,
    output logic              gated_o
`ifdef CG_GATE_STATS_EN
    ,
    output logic [15:0]       gcnt_o
`endif
);
    typedef enum logic [1:0] {S_RUN = 2'd0, S_OFF = 2'd1, S_WAKE = 2'd2} state_t;

    localparam logic [3:0] WAKE_INIT = 4'(WAKE_CYC - 1);

    state_t            state_q, state_d;
    logic [IDLE_W-1:0] cnt_q, cnt_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [IDLE_W:0]   cnt_inc;
    logic              idle, en, gate_q;

    assign idle    = !busy_i && !force_i;
    assign cnt_inc = {1'b0, cnt_q} + (IDLE_W+1)'(1);

    always_ff @(posedge CLKIN) begin
        if (!RSTN) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_RUN: begin
                if (idle && thresh_i != '0) begin
                    // Compare one bit wider so a saturated counter still reaches any threshold.
                    if (cnt_inc >= {1'b0, thresh_i}) begin
                        state_d = S_OFF;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc[IDLE_W] ? cnt_q : cnt_inc[IDLE_W-1:0];
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            S_OFF: begin
                cnt_d = '0;
                if (!idle) begin
                    state_d = S_WAKE;
                    wcnt_d  = WAKE_INIT;
                end
            end
            S_WAKE: begin
                cnt_d = '0;
                if (wcnt_q == 4'd0) state_d = S_RUN;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        en      = (state_q != S_OFF);
        ready_o = (state_q == S_RUN);
        gated_o = (state_q == S_OFF);
    end

    // Latch is closed while CLKIN is high, so enable changes only land between pulses.
    always_latch begin
        if (!CLKIN) gate_q <= en | te_i;
    end

    assign clk_o = CLKIN & gate_q;

`ifdef CG_GATE_STATS_EN
    logic [15:0] gcnt_q;
    always_ff @(posedge CLKIN) begin
        if (!RSTN)
            gcnt_q <= '0;
        else if (state_q == S_RUN && state_d == S_OFF && gcnt_q != 16'hFFFF)
            gcnt_q <= gcnt_q + 16'd1;
    end
    assign gcnt_o = gcnt_q;
`endif
endmodule

module multi_channel_clock_gater #(
    parameter int NUM_CH   = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              CLKIN,
    input  logic              RSTN,
    input  logic              TE,
    input  logic [NUM_CH-1:0] BUSY,
    input  logic [NUM_CH-1:0] FORCE_ON,
    input  logic [IDLE_W-1:0] IDLE_THRESH,
    output logic [NUM_CH-1:0] CLKOUT,
    output logic [NUM_CH-1:0] CH_READY,
    output logic [NUM_CH-1:0] GATED
`ifdef CG_GATE_STATS_EN
    ,
    output logic [NUM_CH*16-1:0] GATE_CNT
`endif
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mcg_channel #(.IDLE_W(IDLE_W), .WAKE_CYC(WAKE_CYC)) u_ch (
            .CLKIN    (CLKIN),
            .RSTN     (RSTN),
            .te_i     (TE),
            .busy_i   (BUSY[i]),
            .force_i  (FORCE_ON[i]),
            .thresh_i (IDLE_THRESH),
            .clk_o    (CLKOUT[i]),
            .ready_o  (CH_READY[i]),
            .gated_o  (GATED[i])
`ifdef CG_GATE_STATS_EN
            ,
            .gcnt_o   (GATE_CNT[i*16 +: 16])
`endif
        );
    end
endmodule
